// File: rtl/tb_ctrl_pkg.sv
// Shared types and sizing helpers for the result checker.
// Imported by test_result_checker and word_compare.
package tb_ctrl_pkg;

  typedef enum logic [1:0] {
    eIDLE,
    eCHECK,
    eDONE
  } checker_state_e;

  // max(1, $clog2(n)) so single-entry counters/indices still get one bit
  function automatic int width_of(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

  function automatic int slice_lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/test_result_checker_if.sv
// DUT-output stream handshake: producer drives valid/data, checker drives ready.
interface test_result_checker_if #(
  parameter int WORD_SIZE = 16,
  parameter int NUM_WORDS = 1
);
  logic                                  valid_i;
  logic                                  ready_o;
  logic signed [NUM_WORDS*WORD_SIZE-1:0] data_i;

  modport master (output valid_i, output data_i, input ready_o);
  modport slave  (input valid_i, input data_i, output ready_o);
endinterface

// File: rtl/test_result_checker_word_compare.sv
// Per-word comparators OR-reduced into one vector mismatch bit.
// CHECKER_TOLERANCE_EN selects |a-b| <= TOLERANCE instead of exact equality.
module word_compare
  import tb_ctrl_pkg::*;
#(
  parameter int WORD_SIZE = 16,
  parameter int NUM_WORDS = 1,
  parameter int TOLERANCE = 0
) (
  input  logic signed [NUM_WORDS*WORD_SIZE-1:0] data,
  input  logic        [NUM_WORDS*WORD_SIZE-1:0] expected,
  output logic                                  mismatch
);

  logic [NUM_WORDS-1:0] word_miss;

  for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_word
    logic signed [WORD_SIZE-1:0] a;
    logic signed [WORD_SIZE-1:0] b;
    assign a = data[slice_lsb(gi, WORD_SIZE) +: WORD_SIZE];
    assign b = expected[slice_lsb(gi, WORD_SIZE) +: WORD_SIZE];
`ifdef CHECKER_TOLERANCE_EN
    // One extra bit keeps the difference and its magnitude from overflowing
    localparam logic [WORD_SIZE:0] TOL = TOLERANCE[WORD_SIZE:0];
    logic signed [WORD_SIZE:0] diff;
    logic        [WORD_SIZE:0] mag;
    assign diff          = {a[WORD_SIZE-1], a} - {b[WORD_SIZE-1], b};
    assign mag           = diff[WORD_SIZE] ? -diff : diff;
    assign word_miss[gi] = (mag > TOL);
`else
    assign word_miss[gi] = (a != b);
`endif
  end

  assign mismatch = |word_miss;

endmodule

// File: rtl/test_result_checker.sv
// Consumes the DUT output stream, checks it against an expected ROM and reports pass/fail.
// Optional build macro: CHECKER_TOLERANCE_EN (tolerance compare in word_compare).
module test_result_checker
  import tb_ctrl_pkg::*;
#(
  parameter int    WORD_SIZE            = 16,
  parameter int    NUM_WORDS            = 1,
  parameter int    NUM_TESTS            = 1,
  parameter string EXPECTED_OUTPUT_FILE = "expected.mif",
  parameter int    TOLERANCE            = 0,
  // Expected ROM contents; vector k at [k*VW +: VW]
  parameter logic [NUM_TESTS*NUM_WORDS*WORD_SIZE-1:0] EXPECTED_INIT = '0,
  localparam int   VW                   = NUM_WORDS * WORD_SIZE,
  localparam int   CW                   = width_of(NUM_TESTS + 1),
  localparam int   IW                   = width_of(NUM_TESTS)
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   start_i,
  test_result_checker_if.slave   dut_out,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   pass_o,
  output logic [CW-1:0]          error_count_o,
  output logic [IW-1:0]          first_fail_idx_o,
  output logic                   fail_seen_o
);

  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_TESTS - 1);
  localparam logic [CW-1:0] MAX_COUNT = CW'(NUM_TESTS);

  checker_state_e state_r, state_n;
  logic [IW-1:0]  test_idx_r, test_idx_n;
  logic [VW-1:0]  expected_r;
  logic           clear_run;
  logic           accept;
  logic           mismatch;

  logic [VW-1:0] rom [NUM_TESTS];

  initial begin
    for (int k = 0; k < NUM_TESTS; k++) begin
      rom[k] = EXPECTED_INIT[k*VW +: VW];
    end
  end

  // Addressed by the next index so expected_r lines up with test_idx_r every cycle
  always_ff @(posedge clk_i) begin
    expected_r <= rom[test_idx_n];
  end

  always_comb begin
    state_n    = state_r;
    test_idx_n = test_idx_r;
    clear_run  = 1'b0;
    accept     = 1'b0;
    unique case (state_r)
      eIDLE, eDONE: begin
        if (start_i) begin
          state_n    = eCHECK;
          test_idx_n = '0;
          clear_run  = 1'b1;
        end
      end
      eCHECK: begin
        if (dut_out.valid_i) begin
          accept = 1'b1;
          if (test_idx_r == LAST_IDX) begin
            state_n    = eDONE;
            test_idx_n = '0;
          end else begin
            test_idx_n = test_idx_r + 1'b1;
          end
        end
      end
      default: state_n = eIDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r    <= eIDLE;
      test_idx_r <= '0;
    end else begin
      state_r    <= state_n;
      test_idx_r <= test_idx_n;
    end
  end

  word_compare #(
    .WORD_SIZE (WORD_SIZE),
    .NUM_WORDS (NUM_WORDS),
    .TOLERANCE (TOLERANCE)
  ) u_word_compare (
    .data     (dut_out.data_i),
    .expected (expected_r),
    .mismatch (mismatch)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      error_count_o    <= '0;
      first_fail_idx_o <= '0;
      fail_seen_o      <= 1'b0;
    end else if (clear_run) begin
      error_count_o    <= '0;
      first_fail_idx_o <= '0;
      fail_seen_o      <= 1'b0;
    end else if (accept && mismatch) begin
      if (error_count_o != MAX_COUNT) begin
        error_count_o <= error_count_o + 1'b1;
      end
      if (!fail_seen_o) begin
        first_fail_idx_o <= test_idx_r;
        fail_seen_o      <= 1'b1;
      end
    end
  end

  assign dut_out.ready_o = (state_r == eCHECK);
  assign busy_o          = (state_r == eCHECK);
  assign done_o          = (state_r == eDONE);
  assign pass_o          = (state_r == eDONE) && (error_count_o == '0);

endmodule

// File: tb/tb_test_result_checker.sv
// Directed bench: 4-vector checker (ROM {1,2,3,4}) plus a 2-vector checker (ROM {100,-5}, TOLERANCE=2).
module tb_test_result_checker;

  logic clk = 1'b0;
  logic reset_i = 1'b1;
  logic start_i = 1'b0;
  logic start2_i = 1'b0;
  always #5 clk = ~clk;

  test_result_checker_if #(.WORD_SIZE(16), .NUM_WORDS(1)) bus ();
  test_result_checker_if #(.WORD_SIZE(16), .NUM_WORDS(1)) bus2 ();

  logic       busy, done, pass, fail_seen;
  logic [2:0] err_cnt;
  logic [1:0] ff_idx;
  logic       busy2, done2, pass2, fail_seen2;
  logic [1:0] err_cnt2;
  logic [0:0] ff_idx2;

  test_result_checker #(
    .WORD_SIZE(16), .NUM_WORDS(1), .NUM_TESTS(4), .EXPECTED_OUTPUT_FILE(""),
    .TOLERANCE(0), .EXPECTED_INIT({16'd4, 16'd3, 16'd2, 16'd1})
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .dut_out(bus),
    .busy_o(busy), .done_o(done), .pass_o(pass), .error_count_o(err_cnt),
    .first_fail_idx_o(ff_idx), .fail_seen_o(fail_seen)
  );

  test_result_checker #(
    .WORD_SIZE(16), .NUM_WORDS(1), .NUM_TESTS(2), .EXPECTED_OUTPUT_FILE(""),
    .TOLERANCE(2), .EXPECTED_INIT({16'hFFFB, 16'd100})
  ) dut2 (
    .clk_i(clk), .reset_i(reset_i), .start_i(start2_i), .dut_out(bus2),
    .busy_o(busy2), .done_o(done2), .pass_o(pass2), .error_count_o(err_cnt2),
    .first_fail_idx_o(ff_idx2), .fail_seen_o(fail_seen2)
  );

  int n_run = 0;
  int n_fail = 0;
  logic [15:0] exp4 [4] = '{16'd1, 16'd2, 16'd3, 16'd4};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  // Back-to-back run with valid held high; stimulus only
  task automatic send4(input logic [15:0] d0, d1, d2, d3);
    logic [15:0] v [4];
    v = '{d0, d1, d2, d3};
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      bus.valid_i = 1'b1;
      bus.data_i  = v[i];
      $display("[TB] tx idx=%0d data=%0d", i, $signed(v[i]));
      tick();
    end
    bus.valid_i = 1'b0;
  endtask

  task automatic test_reset();
    bus.valid_i = 1'b0; bus.data_i = '0;
    bus2.valid_i = 1'b0; bus2.data_i = '0;
    tick(); tick();
    n_run++;
    if ({busy, done, pass, fail_seen, bus.ready_o} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b, expected 00000", {busy, done, pass, fail_seen, bus.ready_o});
    end
    n_run++;
    if (err_cnt !== 3'd0 || ff_idx !== 2'd0) begin
      n_fail++; $display("FAIL reset_counts: got err=%0d idx=%0d, expected 0 0", err_cnt, ff_idx);
    end
    reset_i = 1'b0;
    // valid in eIDLE must be ignored
    bus.valid_i = 1'b1; bus.data_i = 16'd77;
    tick(); tick();
    n_run++;
    if (bus.ready_o !== 1'b0 || busy !== 1'b0 || err_cnt !== 3'd0) begin
      n_fail++; $display("FAIL idle_valid: got ready=%b busy=%b err=%0d, expected 0 0 0", bus.ready_o, busy, err_cnt);
    end
    bus.valid_i = 1'b0;
  endtask

  task automatic test_all_pass();
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      bus.valid_i = 1'b1;
      bus.data_i  = exp4[i];
      $display("[TB] tx idx=%0d data=%0d", i, exp4[i]);
      tick();
      if (i < 3) begin
        n_run++;
        if (done !== 1'b0 || busy !== 1'b1) begin
          n_fail++; $display("FAIL pass_midrun_%0d: got done=%b busy=%b, expected 0 1", i, done, busy);
        end
      end
    end
    bus.valid_i = 1'b0;
    n_run++;
    if (done !== 1'b1 || pass !== 1'b1 || err_cnt !== 3'd0 || fail_seen !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL all_pass: got done=%b pass=%b err=%0d seen=%b busy=%b, expected 1 1 0 0 0",
                         done, pass, err_cnt, fail_seen, busy);
    end
  endtask

  task automatic test_mismatch();
    send4(16'd1, 16'd9, 16'd3, 16'd7);
    n_run++;
    if (done !== 1'b1 || pass !== 1'b0 || err_cnt !== 3'd2) begin
      n_fail++; $display("FAIL mismatch_count: got done=%b pass=%b err=%0d, expected 1 0 2", done, pass, err_cnt);
    end
    n_run++;
    if (ff_idx !== 2'd1 || fail_seen !== 1'b1) begin
      n_fail++; $display("FAIL mismatch_first: got idx=%0d seen=%b, expected 1 1", ff_idx, fail_seen);
    end
  endtask

  task automatic test_restart_all_wrong();
    send4(16'd5, 16'd6, 16'd7, 16'd8);
    n_run++;
    if (err_cnt !== 3'd4 || ff_idx !== 2'd0 || fail_seen !== 1'b1 || pass !== 1'b0 || done !== 1'b1) begin
      n_fail++; $display("FAIL all_wrong: got err=%0d idx=%0d seen=%b pass=%b done=%b, expected 4 0 1 0 1",
                         err_cnt, ff_idx, fail_seen, pass, done);
    end
  endtask

  task automatic test_gaps();
    logic [9:0] pat;
    int acc;
    pat = 10'b0100100101;  // consumed LSB first: 1,0,1,0,0,1,0,0,1,0
    acc = 0;
    pulse_start();
    for (int c = 0; c < 10; c++) begin
      bus.valid_i = pat[c];
      bus.data_i  = (acc < 4) ? exp4[acc] : 16'd0;
      start_i     = (c == 3);  // start during eCHECK is ignored
      if (pat[c]) $display("[TB] tx idx=%0d data=%0d", acc, bus.data_i);
      tick();
      start_i = 1'b0;
      if (pat[c]) acc++;
      n_run++;
      if (done !== (acc == 4)) begin
        n_fail++; $display("FAIL gaps_done_c%0d: got %b, expected %b", c, done, (acc == 4));
      end
    end
    for (int c = 0; c < 3; c++) begin
      bus.valid_i = 1'b1;
      bus.data_i  = 16'd99;
      tick();
      n_run++;
      if (bus.ready_o !== 1'b0 || err_cnt !== 3'd0 || done !== 1'b1 || pass !== 1'b1) begin
        n_fail++; $display("FAIL done_valid_c%0d: got ready=%b err=%0d done=%b pass=%b, expected 0 0 1 1",
                           c, bus.ready_o, err_cnt, done, pass);
      end
    end
    bus.valid_i = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    pulse_start();
    bus.valid_i = 1'b1; bus.data_i = 16'd50; tick();
    bus.data_i = 16'd2; tick();
    bus.valid_i = 1'b0;
    n_run++;
    if (err_cnt !== 3'd1 || fail_seen !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset: got err=%0d seen=%b busy=%b, expected 1 1 1", err_cnt, fail_seen, busy);
    end
    #3 reset_i = 1'b1;
    #1;
    n_run++;
    if ({busy, done, pass, fail_seen, bus.ready_o} !== 5'b0 || err_cnt !== 3'd0 || ff_idx !== 2'd0) begin
      n_fail++; $display("FAIL async_reset: got flags=%b err=%0d idx=%0d, expected 00000 0 0",
                         {busy, done, pass, fail_seen, bus.ready_o}, err_cnt, ff_idx);
    end
    tick();
    reset_i = 1'b0;
    send4(16'd1, 16'd2, 16'd3, 16'd4);
    n_run++;
    if (pass !== 1'b1 || err_cnt !== 3'd0) begin
      n_fail++; $display("FAIL after_reset_run: got pass=%b err=%0d, expected 1 0", pass, err_cnt);
    end
  endtask

  task automatic test_tolerance();
    logic [1:0] exp_err;
    logic [0:0] exp_idx;
`ifdef CHECKER_TOLERANCE_EN
    exp_err = 2'd1; exp_idx = 1'b1;
`else
    exp_err = 2'd2; exp_idx = 1'b0;
`endif
    start2_i = 1'b1; tick(); start2_i = 1'b0;
    bus2.valid_i = 1'b1; bus2.data_i = 16'd102;
    $display("[TB] tx2 idx=0 data=102");
    tick();
    bus2.data_i = 16'hFFF8;
    $display("[TB] tx2 idx=1 data=-8");
    tick();
    bus2.valid_i = 1'b0;
    n_run++;
    if (done2 !== 1'b1 || err_cnt2 !== exp_err || ff_idx2 !== exp_idx || pass2 !== 1'b0) begin
      n_fail++; $display("FAIL tolerance: got done=%b err=%0d idx=%0d pass=%b, expected 1 %0d %0d 0",
                         done2, err_cnt2, ff_idx2, pass2, exp_err, exp_idx);
    end
  endtask

  initial begin
    test_reset();
    test_all_pass();
    test_mismatch();
    test_restart_all_wrong();
    test_gaps();
    test_reset_mid_run();
    test_tolerance();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
